// File: rtl/scale_fifo_pkg.sv
// Shared definitions for the scaler line FIFO.
// Level width helper, default thresholds and the registered flag bundle.
package scale_fifo_pkg;

  localparam int AF_DEF = 1020;
  localparam int AE_DEF = 4;

  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
  } fifo_flags_t;

  function automatic int lvl_w(input int dw);
    return dw + 1;
  endfunction

endpackage

// File: rtl/scale_fifo_sdp_ram.sv
// Simple dual-port RAM, registered read port.
// The FIFO never reads and writes one address in the same cycle.
module scale_fifo_sdp_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Output register holds between reads; only it is reset.
  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/scale_sync_fifo.sv
// Single-clock scaler FIFO with thresholds, level and sticky errors.
// Define SCALE_FIFO_FWFT_EN for first-word-fall-through reads.
module scale_sync_fifo
  import scale_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH_WIDTH = 11,
  parameter int AF_DEFAULT  = AF_DEF,
  parameter int AE_DEFAULT  = AE_DEF,
  localparam int LW = lvl_w(DEPTH_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  wr_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_empty,
  input  logic [LW-1:0]         af_thresh,
  input  logic [LW-1:0]         ae_thresh,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [LW-1:0]         water_level,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam logic [LW-1:0] FULL_LVL =
    {1'b1, {DEPTH_WIDTH{1'b0}}};

  if (DATA_WIDTH < 1 || DATA_WIDTH > 1152 ||
      DEPTH_WIDTH < 4 || DEPTH_WIDTH > 20 ||
      AF_DEFAULT < 0 || AE_DEFAULT < 0) begin : g_bad_cfg
    $error("scale_sync_fifo: parameter out of range");
  end

  fifo_flags_t            flags;
  logic [DEPTH_WIDTH-1:0] wr_ptr;
  logic [DEPTH_WIDTH-1:0] rd_ptr;
  logic [LW-1:0]          level;
  logic [LW-1:0]          level_nxt;
  logic                   wr_acc;
  logic                   rd_acc;
  logic                   ram_rd;
  logic                   empty_nxt;

  // Accept decisions use only registered flags.
  assign wr_acc    = wr_en & ~flags.full;
  assign rd_acc    = rd_en & ~flags.empty;
  assign level_nxt = level + LW'(wr_acc) - LW'(rd_acc);

`ifdef SCALE_FIFO_FWFT_EN
  logic [LW-1:0] ram_cnt;
  logic          out_valid;
  logic          out_valid_nxt;

  // Refill the output register when it is free or being popped.
  assign ram_rd = (ram_cnt != '0) && (!out_valid || rd_acc);
  assign out_valid_nxt = ram_rd | (out_valid & ~rd_acc);
  assign empty_nxt = ~out_valid_nxt;
  assign rd_valid  = ~flags.empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_cnt   <= '0;
      out_valid <= 1'b0;
    end else begin
      ram_cnt   <= ram_cnt + LW'(wr_acc) - LW'(ram_rd);
      out_valid <= out_valid_nxt;
    end
  end
`else
  logic valid_q;

  assign ram_rd    = rd_acc;
  assign empty_nxt = (level_nxt == '0);
  assign rd_valid  = valid_q;

  always_ff @(posedge clk) begin
    if (rst) valid_q <= 1'b0;
    else valid_q <= rd_acc;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      flags     <= '{full: 1'b0, empty: 1'b1,
                     afull: 1'b0, aempty: 1'b1};
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr + DEPTH_WIDTH'(wr_acc);
      rd_ptr       <= rd_ptr + DEPTH_WIDTH'(ram_rd);
      level        <= level_nxt;
      flags.full   <= (level_nxt == FULL_LVL);
      flags.empty  <= empty_nxt;
      flags.afull  <= (level_nxt >= af_thresh);
      flags.aempty <= (level_nxt <= ae_thresh);
      // A new violation wins over clr_err.
      overflow  <= (wr_en & flags.full) |
                   (overflow & ~clr_err);
      underflow <= (rd_en & flags.empty) |
                   (underflow & ~clr_err);
    end
  end

  scale_fifo_sdp_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(DEPTH_WIDTH)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_acc),
    .wr_addr(wr_ptr),
    .wr_data(wr_data),
    .rd_en  (ram_rd),
    .rd_addr(rd_ptr),
    .rd_data(rd_data)
  );

  assign wr_full      = flags.full;
  assign rd_empty     = flags.empty;
  assign almost_full  = flags.afull;
  assign almost_empty = flags.aempty;
  assign water_level  = level;

endmodule

// File: tb/tb_scale_sync_fifo.sv
// Bench for scale_sync_fifo: queue reference model, directed and random traffic.
// Standard-mode scenarios, or the FWFT scenario when SCALE_FIFO_FWFT_EN is set.
module tb_scale_sync_fifo;

  localparam int DW    = 16;
  localparam int AW    = 11;
  localparam int LW    = AW + 1;
  localparam int DEPTH = 2048;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_en = 1'b0;
  logic          wr_full;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_empty;
  logic [LW-1:0] af_thresh = 12'd1020;
  logic [LW-1:0] ae_thresh = 12'd4;
  logic          almost_full;
  logic          almost_empty;
  logic [LW-1:0] water_level;
  logic          overflow;
  logic          underflow;
  logic          clr_err = 1'b0;

  always #5 clk = ~clk;

  scale_sync_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH_WIDTH(AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .wr_full     (wr_full),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_empty    (rd_empty),
    .af_thresh   (af_thresh),
    .ae_thresh   (ae_thresh),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .water_level (water_level),
    .overflow    (overflow),
    .underflow   (underflow),
    .clr_err     (clr_err)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: contents as a queue, flags derived from its size.
  logic [DW-1:0] q[$];
  int            exp_level = 0;
  bit            exp_valid = 0;
  logic [DW-1:0] exp_data = '0;
  bit            exp_ov = 0;
  bit            exp_un = 0;
  bit            exp_af = 0;
  bit            exp_ae = 1;

  task automatic do_reset;
    rst = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    exp_level = 0;
    exp_valid = 0;
    exp_data = '0;
    exp_ov = 0;
    exp_un = 0;
    exp_af = 0;
    exp_ae = 1;
  endtask

  task automatic cycle(input bit we, input logic [DW-1:0] wd,
                       input bit re, input bit ce);
    bit full_b, empty_b;
    wr_en = we;
    wr_data = wd;
    rd_en = re;
    clr_err = ce;
    @(posedge clk);
    full_b = (q.size() == DEPTH);
    empty_b = (q.size() == 0);
    exp_valid = re && !empty_b;
    if (exp_valid) exp_data = q.pop_front();
    if (we && !full_b) q.push_back(wd);
    exp_ov = (we && full_b) || (exp_ov && !ce);
    exp_un = (re && empty_b) || (exp_un && !ce);
    exp_level = q.size();
    exp_af = exp_level >= int'(af_thresh);
    exp_ae = exp_level <= int'(ae_thresh);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    clr_err = 1'b0;
  endtask

`ifndef SCALE_FIFO_FWFT_EN
  task automatic test_reset;
    do_reset();
    checks += 9;
    if (wr_full !== 1'b0) begin errors++;
      $display("FAIL reset_wr_full got=%b exp=0", wr_full); end
    if (rd_empty !== 1'b1) begin errors++;
      $display("FAIL reset_rd_empty got=%b exp=1", rd_empty); end
    if (rd_valid !== 1'b0) begin errors++;
      $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    if (almost_full !== 1'b0) begin errors++;
      $display("FAIL reset_af got=%b exp=0", almost_full); end
    if (almost_empty !== 1'b1) begin errors++;
      $display("FAIL reset_ae got=%b exp=1", almost_empty); end
    if (water_level !== '0) begin errors++;
      $display("FAIL reset_level got=%0d exp=0", water_level); end
    if (overflow !== 1'b0) begin errors++;
      $display("FAIL reset_ovf got=%b exp=0", overflow); end
    if (underflow !== 1'b0) begin errors++;
      $display("FAIL reset_udf got=%b exp=0", underflow); end
    if (rd_data !== '0) begin errors++;
      $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
  endtask

  task automatic test_fill;
    af_thresh = 12'd1020;
    ae_thresh = 12'd4;
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 16'(16'hFFFF - i), 1'b0, 1'b0);
      checks += 4;
      if (int'(water_level) !== i + 1) begin errors++;
        $display("FAIL fill_level i=%0d got=%0d exp=%0d",
                 i, water_level, i + 1); end
      if (wr_full !== (i == DEPTH - 1)) begin errors++;
        $display("FAIL fill_full i=%0d got=%b", i, wr_full); end
      if (almost_full !== (i + 1 >= 1020)) begin errors++;
        $display("FAIL fill_af i=%0d got=%b", i, almost_full); end
      if (rd_empty !== 1'b0) begin errors++;
        $display("FAIL fill_empty i=%0d got=%b", i, rd_empty); end
    end
  endtask

  task automatic test_drain;
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      checks += 5;
      if (rd_valid !== 1'b1) begin errors++;
        $display("FAIL drain_valid i=%0d got=%b exp=1", i, rd_valid); end
      if (rd_data !== 16'(16'hFFFF - i)) begin errors++;
        $display("FAIL drain_data i=%0d got=%h exp=%h",
                 i, rd_data, 16'(16'hFFFF - i)); end
      if (int'(water_level) !== DEPTH - 1 - i) begin errors++;
        $display("FAIL drain_level i=%0d got=%0d", i, water_level); end
      if (almost_empty !== (DEPTH - 1 - i <= 4)) begin errors++;
        $display("FAIL drain_ae i=%0d got=%b", i, almost_empty); end
      if (rd_empty !== (i == DEPTH - 1)) begin errors++;
        $display("FAIL drain_empty i=%0d got=%b", i, rd_empty); end
    end
    cycle(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (rd_valid !== 1'b0) begin errors++;
      $display("FAIL drain_valid_pulse got=%b exp=0", rd_valid); end
  endtask

  task automatic test_steady;
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, 16'($urandom), 1'b1, 1'b0);
      checks += 4;
      if (water_level !== 12'd10) begin errors++;
        $display("FAIL steady_level i=%0d got=%0d exp=10",
                 i, water_level); end
      if (rd_valid !== 1'b1 || rd_data !== exp_data) begin errors++;
        $display("FAIL steady_data i=%0d got=%b/%h exp=1/%h",
                 i, rd_valid, rd_data, exp_data); end
      if (overflow !== 1'b0) begin errors++;
        $display("FAIL steady_ovf got=%b exp=0", overflow); end
      if (underflow !== 1'b0) begin errors++;
        $display("FAIL steady_udf got=%b exp=0", underflow); end
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (rd_data !== exp_data) begin errors++;
        $display("FAIL steady_tail i=%0d got=%h exp=%h",
                 i, rd_data, exp_data); end
    end
  endtask

  task automatic test_errors;
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, 16'(i), 1'b0, 1'b0);
    cycle(1'b1, 16'hDEAD, 1'b0, 1'b0);
    checks += 2;
    if (overflow !== 1'b1) begin errors++;
      $display("FAIL ovf_set got=%b exp=1", overflow); end
    if (int'(water_level) !== DEPTH) begin errors++;
      $display("FAIL ovf_level got=%0d exp=%0d", water_level, DEPTH); end
    cycle(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (overflow !== 1'b1) begin errors++;
      $display("FAIL ovf_hold got=%b exp=1", overflow); end
    cycle(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b0) begin errors++;
      $display("FAIL ovf_clr got=%b exp=0", overflow); end
    cycle(1'b1, 16'hBEEF, 1'b1, 1'b0);
    checks += 3;
    if (overflow !== 1'b1) begin errors++;
      $display("FAIL ovf_rw got=%b exp=1", overflow); end
    if (int'(water_level) !== DEPTH - 1) begin errors++;
      $display("FAIL ovf_rw_level got=%0d exp=%0d",
               water_level, DEPTH - 1); end
    if (rd_valid !== 1'b1 || rd_data !== 16'h0000) begin errors++;
      $display("FAIL ovf_rw_data got=%b/%h exp=1/0000",
               rd_valid, rd_data); end
    cycle(1'b1, 16'h0AAA, 1'b0, 1'b0);
    cycle(1'b1, 16'h0BBB, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b1) begin errors++;
      $display("FAIL ovf_set_vs_clr got=%b exp=1", overflow); end
    cycle(1'b0, '0, 1'b0, 1'b1);
    while (q.size() > 0) cycle(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (exp_data !== 16'h0AAA || rd_data !== exp_data) begin errors++;
      $display("FAIL last_word got=%h exp=0aaa", rd_data); end
    cycle(1'b0, '0, 1'b1, 1'b0);
    checks += 2;
    if (underflow !== 1'b1) begin errors++;
      $display("FAIL udf_set got=%b exp=1", underflow); end
    if (rd_valid !== 1'b0) begin errors++;
      $display("FAIL udf_valid got=%b exp=0", rd_valid); end
    cycle(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (underflow !== 1'b0) begin errors++;
      $display("FAIL udf_clr got=%b exp=0", underflow); end
    cycle(1'b1, 16'h5A5A, 1'b1, 1'b0);
    checks += 3;
    if (underflow !== 1'b1) begin errors++;
      $display("FAIL udf_rw got=%b exp=1", underflow); end
    if (water_level !== 12'd1) begin errors++;
      $display("FAIL udf_rw_level got=%0d exp=1", water_level); end
    if (rd_valid !== 1'b0) begin errors++;
      $display("FAIL udf_rw_valid got=%b exp=0", rd_valid); end
    cycle(1'b0, '0, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1);
    checks++;
    if (underflow !== 1'b1) begin errors++;
      $display("FAIL udf_set_vs_clr got=%b exp=1", underflow); end
    cycle(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (underflow !== 1'b0) begin errors++;
      $display("FAIL udf_clr2 got=%b exp=0", underflow); end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 500; i++)
      cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
    checks++;
    if (water_level !== 12'd500) begin errors++;
      $display("FAIL mid_pre_level got=%0d exp=500", water_level); end
    do_reset();
    checks += 3;
    if (water_level !== '0) begin errors++;
      $display("FAIL mid_level got=%0d exp=0", water_level); end
    if (rd_empty !== 1'b1) begin errors++;
      $display("FAIL mid_empty got=%b exp=1", rd_empty); end
    if (wr_full !== 1'b0) begin errors++;
      $display("FAIL mid_full got=%b exp=0", wr_full); end
    cycle(1'b0, '0, 1'b1, 1'b0);
    checks += 3;
    if (rd_valid !== 1'b0) begin errors++;
      $display("FAIL mid_read_valid got=%b exp=0", rd_valid); end
    if (underflow !== 1'b1) begin errors++;
      $display("FAIL mid_read_udf got=%b exp=1", underflow); end
    if (water_level !== '0) begin errors++;
      $display("FAIL mid_read_level got=%0d exp=0", water_level); end
    cycle(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_random;
    int pw;
    for (int n = 0; n < 12000; n++) begin
      pw = (n < 6000) ? 75 : 25;
      if (n % 97 == 0) begin
        af_thresh = 12'($urandom_range(0, 2200));
        ae_thresh = 12'($urandom_range(0, 2200));
      end
      cycle($urandom_range(0, 99) < pw, 16'($urandom),
            $urandom_range(0, 99) < 100 - pw,
            $urandom_range(0, 49) == 0);
      checks++;
      if (int'(water_level) !== exp_level ||
          wr_full !== (exp_level == DEPTH) ||
          rd_empty !== (exp_level == 0) ||
          almost_full !== exp_af || almost_empty !== exp_ae ||
          rd_valid !== exp_valid || rd_data !== exp_data ||
          overflow !== exp_ov || underflow !== exp_un) begin
        errors++;
        if (errors < 30)
          $display("FAIL rand n=%0d got lvl=%0d f=%b e=%b af=%b ae=%b v=%b d=%h o=%b u=%b exp lvl=%0d af=%b ae=%b v=%b d=%h o=%b u=%b",
                   n, water_level, wr_full, rd_empty, almost_full,
                   almost_empty, rd_valid, rd_data, overflow,
                   underflow, exp_level, exp_af, exp_ae, exp_valid,
                   exp_data, exp_ov, exp_un);
      end
    end
  endtask
`else
  task automatic test_fwft;
    do_reset();
    wr_data = 16'h1234;
    wr_en = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    checks += 2;
    if (rd_empty !== 1'b1) begin errors++;
      $display("FAIL fwft_empty_n got=%b exp=1", rd_empty); end
    if (water_level !== 12'd1) begin errors++;
      $display("FAIL fwft_level got=%0d exp=1", water_level); end
    @(posedge clk);
    #1;
    checks += 3;
    if (rd_data !== 16'h1234) begin errors++;
      $display("FAIL fwft_data got=%h exp=1234", rd_data); end
    if (rd_valid !== 1'b1) begin errors++;
      $display("FAIL fwft_valid got=%b exp=1", rd_valid); end
    if (rd_empty !== 1'b0) begin errors++;
      $display("FAIL fwft_empty got=%b exp=0", rd_empty); end
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    checks += 3;
    if (rd_empty !== 1'b1) begin errors++;
      $display("FAIL fwft_pop_empty got=%b exp=1", rd_empty); end
    if (rd_valid !== 1'b0) begin errors++;
      $display("FAIL fwft_pop_valid got=%b exp=0", rd_valid); end
    if (water_level !== '0) begin errors++;
      $display("FAIL fwft_pop_level got=%0d exp=0", water_level); end
  endtask
`endif

  initial begin
`ifndef SCALE_FIFO_FWFT_EN
    test_reset();
    test_fill();
    test_drain();
    test_steady();
    test_errors();
    test_reset_mid();
    test_random();
`else
    test_fwft();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
